// File: rtl/div_23_rem_stage_pkg.sv
// div23_pkg: shared constants and FIFO entry type for the divide-by-23 remainder stage
package div23_pkg;
  localparam int X_W = 16;
  localparam int Q_W = 12;
  localparam int R_W = 5;
  localparam int DIVISOR = 23;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [Q_W-1:0] q;
    logic [R_W-1:0] r;
    logic err;
  } div23_entry_t;
endpackage

// File: rtl/div_23_rem_stage_if.sv
// div_23_rem_stage_if: sample input, divider quotient return, output stream and error status
interface div_23_rem_stage_if import div23_pkg::*; ;
  logic in_valid;
  logic in_ready;
  logic [X_W-1:0] in_x;
  logic [Q_W-1:0] q_in;
  logic out_valid;
  logic out_ready;
  logic [Q_W-1:0] out_q;
  logic [R_W-1:0] out_r;
  logic out_err;
  logic [15:0] err_cnt;
  logic err_sticky;
  modport master (
    output in_valid, in_x, q_in, out_ready,
    input in_ready, out_valid, out_q, out_r, out_err, err_cnt, err_sticky
  );
  modport slave (
    input in_valid, in_x, q_in, out_ready,
    output in_ready, out_valid, out_q, out_r, out_err, err_cnt, err_sticky
  );
endinterface

// File: rtl/div_23_rem_stage_fifo.sv
// div23_fifo: N-entry FIFO of {q, r, err} with count, full and empty
module div23_fifo import div23_pkg::*; #(
  parameter int N = 4,
  localparam int AW = $clog2(N),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  div23_entry_t din,
  input  logic         pop,
  output div23_entry_t dout,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  div23_entry_t mem [N];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == CW'(N);
  assign empty = count == '0;
endmodule

// File: rtl/div_23_rem_stage.sv
// div_23_rem_stage: realigns X with the divider's Q, rebuilds R=X-23*Q, range-checks it and queues {Q,R,err}
module div_23_rem_stage import div23_pkg::*; (
  input logic clk,
  input logic rst_n,
  div_23_rem_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [LAT-1:0] vld;
  logic [X_W-1:0] xd [LAT];
  logic [CW-1:0] count, inflight;
  logic accept, push, pop, full, empty, err, err_sticky;
  logic [X_W+1:0] qm, d;
  logic [15:0] err_cnt;
  div23_entry_t din, dout;
  assign accept = bus.in_valid & bus.in_ready;
  assign inflight = CW'($countones(vld));
  assign bus.in_ready = (count + inflight) < CW'(DEPTH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) xd[i] <= '0;
    end else begin
      vld <= {vld[LAT-2:0], accept};
      xd[0] <= bus.in_x;
      for (int i = 1; i < LAT; i++) xd[i] <= xd[i-1];
    end
  end
  assign qm = (X_W+2)'(bus.q_in) * (X_W+2)'(DIVISOR);
  assign d = {2'b00, xd[LAT-1]} - qm;
  assign err = d[X_W+1] | (d >= (X_W+2)'(DIVISOR));
  assign din = '{q: bus.q_in, r: d[R_W-1:0], err: err};
  assign push = vld[LAT-1];
  assign pop = bus.out_valid & bus.out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_sticky <= 1'b0;
    end else if (push && err) begin
      err_cnt <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
      err_sticky <= 1'b1;
    end
  end
  div23_fifo #(.N(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(dout), .count(count), .full(full), .empty(empty)
  );
  assign bus.out_valid = !empty;
  assign bus.out_q = dout.q;
  assign bus.out_r = dout.r;
  assign bus.out_err = dout.err;
  assign bus.err_cnt = err_cnt;
  assign bus.err_sticky = err_sticky;
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule
